// File: rtl/ram_dma_pkg.sv
// ram_dma shared types: FSM state and transfer mode encodings.
// Imported by the ram_dma block-transfer initiator.
package ram_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FILL  = 3'd4,
    ST_DONE  = 3'd5
  } dma_state_t;

  typedef enum logic {
    DMA_COPY = 1'b0,
    DMA_FILL = 1'b1
  } dma_mode_t;

endpackage

// File: rtl/ram_dma.sv
// Block copy/fill initiator for the on-chip ram port.
// Second bus master beside the Z80, arbitrated via bus_req/bus_ack.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_ack,
  output logic              mem_ena,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  dma_state_t        state, state_d;
  dma_mode_t         mode_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  rem_q;
  logic [DATA_W-1:0] fill_q;

  logic latch, step_src, step_dst, last;

  assign last = (rem_q == LEN_W'(1));

  always_comb begin
    state_d  = state;
    latch    = 1'b0;
    step_src = 1'b0;
    step_dst = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            latch   = 1'b1;
            state_d = ST_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        if (bus_ack)
          state_d = (mode_q == DMA_FILL) ? ST_FILL : ST_READ;
      end
      ST_READ: begin
        if (bus_ack) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // a lost grant may have clobbered dout: re-read same byte
        if (bus_ack) begin
          step_src = 1'b1;
          step_dst = 1'b1;
          state_d  = last ? ST_DONE : ST_READ;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_FILL: begin
        if (bus_ack) begin
          step_dst = 1'b1;
          if (last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_q <= DMA_COPY;
      src_q  <= '0;
      dst_q  <= '0;
      rem_q  <= '0;
      fill_q <= '0;
    end else begin
      state <= state_d;
      if (latch) begin
        mode_q <= dma_mode_t'(mode);
        src_q  <= src_addr;
        dst_q  <= dst_addr;
        rem_q  <= len;
        fill_q <= fill_val;
      end else begin
        if (step_src) src_q <= src_q + ADDR_W'(1);
        if (step_dst) begin
          dst_q <= dst_q + ADDR_W'(1);
          rem_q <= rem_q - LEN_W'(1);
        end
      end
    end
  end

  logic st_rd, st_wr, st_fl;

  assign st_rd = (state == ST_READ);
  assign st_wr = (state == ST_WRITE);
  assign st_fl = (state == ST_FILL);

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign bus_req = (state == ST_REQ) | st_rd | st_wr | st_fl;

  assign mem_ena = bus_ack & (st_rd | st_wr | st_fl);
  assign mem_rd  = bus_ack & st_rd;
  assign mem_wr  = bus_ack & (st_wr | st_fl);

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    unique case (1'b1)
      st_rd: mem_addr = src_q;
      st_wr: begin
        mem_addr = dst_q;
        mem_din  = mem_dout;
      end
      st_fl: begin
        mem_addr = dst_q;
        mem_din  = fill_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ram_dma.md
# ram_dma

Block-transfer initiator for the on-chip `ram` port. It copies or fills a contiguous byte range by driving the RAM's `ena`/`rd`/`wr`/`addr`/`din` inputs and consuming its registered `dout`. It sits beside the Z80 core as a second bus master and arbitrates through a `bus_req`/`bus_ack` pair, in the style of BUSREQ/BUSACK. Copy semantics are byte-sequential and ascending, like Z80 LDIR.

## Interface
- `ADDR_W`, 16, RAM address width; must match the attached `ram` instance.
- `DATA_W`, 8, data width.
- `LEN_W`, ADDR_W+1, length width; allows a full 2^ADDR_W transfer.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; latched at start.
- `src_addr`  in  ADDR_W  copy source base; latched at start.
- `dst_addr`  in  ADDR_W  destination base; latched at start.
- `len`  in  LEN_W  byte count; latched at start; 0 = no-op.
- `fill_val`  in  DATA_W  fill byte; latched at start.
- `busy`  out  1  high from the cycle after start is accepted through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.
- `bus_req`  out  1  RAM ownership request.
- `bus_ack`  in  1  RAM ownership grant.
- `mem_ena`, `mem_rd`, `mem_wr`  out  1  drive the RAM `ena`, `rd` and `wr` inputs.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_din`  out  DATA_W  RAM write data.
- `mem_dout`  in  DATA_W  RAM registered read data.

## Operation
- States: IDLE, REQ, READ, WRITE, FILL, DONE. Encoding lives in the package.
- IDLE:
  - `start`=1 with `len`≠0 latches all operands and goes to REQ.
  - `start`=1 with `len`=0 goes directly to DONE; no bus request and no memory access.
- REQ: `bus_req`=1. On `bus_ack` sampled 1, go to READ (copy) or FILL (fill).
- READ: `mem_ena`=`mem_rd`=1, `mem_addr`=src pointer. Next state WRITE.
- WRITE: `mem_ena`=`mem_wr`=1, `mem_addr`=dst pointer, `mem_din`=`mem_dout`.
  - Then: src pointer +1, dst pointer +1, remaining −1.
  - Next state READ, or DONE if remaining reaches 0.
- FILL: `mem_ena`=`mem_wr`=1, `mem_addr`=dst pointer, `mem_din`=`fill_val`.
  - Then: dst pointer +1, remaining −1.
  - Stay in FILL, or go to DONE if remaining reaches 0.
- DONE: `done`=1, `busy`=1, `bus_req`=0. Next state IDLE.
- `bus_req` is 1 in REQ, READ, WRITE and FILL.
- Pointers increment modulo 2^ADDR_W; wrap from all-ones to 0 is legal and silent.
- Overlap: forward byte-by-byte only. For dst = src+1, every destination byte becomes the first source byte (LDIR replication). This is intended.
- Grant loss: if `bus_ack`=0 in READ, WRITE or FILL:
  - `mem_ena`, `mem_rd` and `mem_wr` are forced to 0 combinationally and the state holds.
  - A stall observed in WRITE returns to READ for the same byte, because RAM `dout` may have been overwritten by another master.
  - Pointers and count do not advance on stalled cycles.
- `start` outside IDLE is ignored.
- Reset mid-transfer: immediate return to IDLE, `bus_req` drops, no `done` pulse. Partially written data is left as is.

## Timing
- Reset values: state IDLE; `busy`, `done`, `bus_req`, `mem_ena`, `mem_rd`, `mem_wr` = 0; `mem_addr`, `mem_din` = 0; all latched operands 0.
- RAM read latency is 1 cycle, so copy costs 2 cycles/byte and fill costs 1 cycle/byte.
- Start-to-done, with `bus_ack` returning 1 on the first REQ cycle:
  - Copy: 1 (REQ) + 2·len + 1 (DONE) cycles.
  - Fill: 1 + len + 1 cycles.
  - `len`=0: `done` in the cycle after start.
- Outputs are decoded from registered state and counters. The only input-to-output combinational paths are:
  - `bus_ack` → `mem_ena`/`mem_rd`/`mem_wr` (stall gating);
  - `mem_dout` → `mem_din`.

## Structure
- Package `ram_dma_pkg`: `dma_state_t` enum and `dma_mode_t` enum (`DMA_COPY`, `DMA_FILL`).
- No sub-module. Pointers, counter and FSM are implemented inline, roughly 150–250 lines.
- The bench instantiates the real `ram` with `ADDR_W`=8 as the responder; the Z80 side is modelled by a bus_ack driver.

## Test plan
- Copy, src=0x10, dst=0x80, len=4, RAM[0x10..0x13]=A1,B2,C3,D4, ack immediate → RAM[0x80..0x83]=A1,B2,C3,D4; `done` exactly 10 cycles after the start edge.
- Fill, dst=0xFE, len=4, fill_val=0x5A → RAM[0xFE], [0xFF], [0x00], [0x01] = 0x5A (wrap); other bytes unchanged.
- Copy len=3, ack dropped for 3 cycles during the second WRITE while the bench writes 0xEE to the source location → second byte re-read and written as 0xEE; no RAM enable asserted during the stall.
- Overlapping copy, src=0x20, dst=0x21, len=3, RAM[0x20]=0x77 → RAM[0x21..0x23]=0x77.
- len=0 start → `done` next cycle, `bus_req` never asserted; `start` pulsed while busy → ignored, no second `done`.
- `rst_n` low for 1 cycle mid-copy → all outputs 0 immediately; no `done`; new start afterwards completes normally.
